drive_arbiter: RTL and testbench

Arbitrates drive commands between the camera-follow path and the IR remote and converts the granted 3-bit drive code into left/right motor duty and direction. It slews duty toward target and brakes through zero before any direction reversal. It also enforces an emergency-stop latch and a camera-command watchdog. It sits between the top-level mode FSM (mode, CAM drive code) and the PWM generators.

---
 rtl/drive_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_drive_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// drive_arbiter: arbitrates CAM / IR drive codes and maps the granted code to motor duty and direction.
// Define DRIVE_RAMP_EN for duty slewing with brake-through-zero reversals; otherwise duty snaps to target.
module drive_arbiter #(
  parameter int RAMP_DIV    = 250000,
  parameter int RAMP_STEP   = 8,
  parameter int HOLD_CYCLES = 5000000,
  parameter int WDOG_CYCLES = 25000000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       cam_valid,
  input  logic [2:0] cam_drive,
  input  logic       ir_valid,
  input  logic [2:0] ir_drive,
  input  logic       estop,
  output logic [1:0] grant,
  output logic [2:0] active_cmd,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       estop_latched,
  output logic       wdog_trip
);

  if (RAMP_DIV < 1 || RAMP_STEP < 1 || RAMP_STEP > 255 || HOLD_CYCLES < 2 || WDOG_CYCLES < 2) begin : g_badCfg
    $error("drive_arbiter: invalid parameter set");
  end

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(WDOG_CYCLES);

  localparam logic [2:0] C_STOP  = 3'd0;
  localparam logic [2:0] C_LEFT  = 3'd1;
  localparam logic [2:0] C_RIGHT = 3'd2;
  localparam logic [2:0] C_SLOW  = 3'd3;
  localparam logic [2:0] C_MED   = 3'd4;
  localparam logic [2:0] C_FAST  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CAM, S_IR, S_ESTOP} state_t;

  state_t          state_q, modeState;
  logic [1:0]      grant_q;
  logic [2:0]      cmd_q;
  logic            estopLatched_q, wdogTrip_q;
  logic [HW-1:0]   holdCnt_q;
  logic [WW-1:0]   wdogCnt_q;
  logic [7:0]      dutyL_q, dutyR_q, dutyL_d, dutyR_d;
  logic            dirL_q, dirR_q, dirL_d, dirR_d;
  logic [7:0]      tgtDutyL, tgtDutyR;
  logic            tgtDirL, tgtDirR;

  always_comb begin
    case (mode)
      2'b01:   modeState = S_CAM;
      2'b10:   modeState = S_IR;
      default: modeState = S_IDLE;
    endcase
  end

  // A mode change always lands on STOP with fresh counters, so any strobe in that cycle is dropped.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      grant_q        <= 2'b00;
      cmd_q          <= C_STOP;
      estopLatched_q <= 1'b0;
      wdogTrip_q     <= 1'b0;
      holdCnt_q      <= '0;
      wdogCnt_q      <= '0;
    end else if (estop) begin
      state_q        <= S_ESTOP;
      grant_q        <= 2'b00;
      cmd_q          <= C_STOP;
      estopLatched_q <= 1'b1;
      holdCnt_q      <= '0;
      wdogCnt_q      <= '0;
    end else if (state_q == S_ESTOP) begin
      if (modeState == S_IDLE) begin
        state_q        <= S_IDLE;
        estopLatched_q <= 1'b0;
      end
    end else if (modeState != state_q) begin
      state_q   <= modeState;
      grant_q   <= (modeState == S_CAM) ? 2'b01 : (modeState == S_IR) ? 2'b10 : 2'b00;
      cmd_q     <= C_STOP;
      holdCnt_q <= '0;
      wdogCnt_q <= '0;
    end else begin
      case (state_q)
        S_CAM: begin
          if (cam_valid) begin
            cmd_q      <= cam_drive;
            wdogCnt_q  <= '0;
            wdogTrip_q <= 1'b0;
          end else if (wdogCnt_q == WW'(WDOG_CYCLES - 1)) begin
            wdogTrip_q <= 1'b1;
            cmd_q      <= C_STOP;
          end else begin
            wdogCnt_q <= wdogCnt_q + WW'(1);
          end
        end
        S_IR: begin
          if (ir_valid) begin
            cmd_q     <= ir_drive;
            holdCnt_q <= HW'(HOLD_CYCLES);
          end else if (holdCnt_q == HW'(1)) begin
            cmd_q     <= C_STOP;
            holdCnt_q <= '0;
          end else if (holdCnt_q != '0) begin
            holdCnt_q <= holdCnt_q - HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // STOP (and the unused codes) keep the present directions so a stop never triggers a reversal.
  always_comb begin
    tgtDutyL = 8'd0;
    tgtDutyR = 8'd0;
    tgtDirL  = dirL_q;
    tgtDirR  = dirR_q;
    case (cmd_q)
      C_LEFT:  begin tgtDirL = 1'b0; tgtDutyL = 8'd96;  tgtDirR = 1'b1; tgtDutyR = 8'd96;  end
      C_RIGHT: begin tgtDirL = 1'b1; tgtDutyL = 8'd96;  tgtDirR = 1'b0; tgtDutyR = 8'd96;  end
      C_SLOW:  begin tgtDirL = 1'b1; tgtDutyL = 8'd64;  tgtDirR = 1'b1; tgtDutyR = 8'd64;  end
      C_MED:   begin tgtDirL = 1'b1; tgtDutyL = 8'd128; tgtDirR = 1'b1; tgtDutyR = 8'd128; end
      C_FAST:  begin tgtDirL = 1'b1; tgtDutyL = 8'd192; tgtDirR = 1'b1; tgtDutyR = 8'd192; end
      default: ;
    endcase
  end

`ifdef DRIVE_RAMP_EN
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(RAMP_DIV - 1));

  function automatic logic [7:0] stepToward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] gap;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      return (gap <= STEP9) ? tgt : cur + STEP9[7:0];
    end
    gap = {1'b0, cur} - {1'b0, tgt};
    return (gap <= STEP9) ? tgt : cur - STEP9[7:0];
  endfunction

  // A reversal first brakes to zero, then spends one whole tick at zero while the direction flips.
  function automatic logic [8:0] slewSide(input logic dir, input logic [7:0] duty,
                                          input logic tdir, input logic [7:0] tduty);
    if (tdir != dir) begin
      if (duty != 8'd0) return {dir, stepToward(duty, 8'd0)};
      return {tdir, 8'd0};
    end
    return {dir, stepToward(duty, tduty)};
  endfunction

  always_comb begin
    {dirL_d, dutyL_d} = {dirL_q, dutyL_q};
    {dirR_d, dutyR_d} = {dirR_q, dutyR_q};
    if (estop || state_q == S_ESTOP) begin
      dutyL_d = 8'd0;
      dutyR_d = 8'd0;
    end else if (tick) begin
      {dirL_d, dutyL_d} = slewSide(dirL_q, dutyL_q, tgtDirL, tgtDutyL);
      {dirR_d, dutyR_d} = slewSide(dirR_q, dutyR_q, tgtDirR, tgtDutyR);
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + PW'(1);
  end
`else
  always_comb begin
    {dirL_d, dutyL_d} = {tgtDirL, tgtDutyL};
    {dirR_d, dutyR_d} = {tgtDirR, tgtDutyR};
    if (estop || state_q == S_ESTOP) begin
      {dirL_d, dutyL_d} = {dirL_q, 8'd0};
      {dirR_d, dutyR_d} = {dirR_q, 8'd0};
    end
  end
`endif

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      dutyL_q <= 8'd0;
      dutyR_q <= 8'd0;
      dirL_q  <= 1'b1;
      dirR_q  <= 1'b1;
    end else begin
      dutyL_q <= dutyL_d;
      dutyR_q <= dutyR_d;
      dirL_q  <= dirL_d;
      dirR_q  <= dirR_d;
    end
  end

  assign grant         = grant_q;
  assign active_cmd    = cmd_q;
  assign duty_l        = dutyL_q;
  assign duty_r        = dutyR_q;
  assign dir_l         = dirL_q;
  assign dir_r         = dirR_q;
  assign estop_latched = estopLatched_q;
  assign wdog_trip     = wdogTrip_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed scenarios plus randomized traffic against a behavioural model of drive_arbiter.
// Works with DRIVE_RAMP_EN defined or undefined; the model follows the same macro.
module tb_drive_arbiter;

  localparam int RDIV  = 4;
  localparam int RSTEP = 16;
  localparam int HOLD  = 100;
  localparam int WDOG  = 200;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       cam_valid = 1'b0;
  logic [2:0] cam_drive = 3'd0;
  logic       ir_valid = 1'b0;
  logic [2:0] ir_drive = 3'd0;
  logic       estop = 1'b0;
  logic [1:0] grant;
  logic [2:0] active_cmd;
  logic [7:0] duty_l, duty_r;
  logic       dir_l, dir_r, estop_latched, wdog_trip;

  int errors = 0;
  int checks = 0;

  always #10 clk_50 = ~clk_50;

  drive_arbiter #(.RAMP_DIV(RDIV), .RAMP_STEP(RSTEP), .HOLD_CYCLES(HOLD), .WDOG_CYCLES(WDOG)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .mode(mode), .cam_valid(cam_valid), .cam_drive(cam_drive),
    .ir_valid(ir_valid), .ir_drive(ir_drive), .estop(estop), .grant(grant), .active_cmd(active_cmd),
    .duty_l(duty_l), .duty_r(duty_r), .dir_l(dir_l), .dir_r(dir_r),
    .estop_latched(estop_latched), .wdog_trip(wdog_trip)
  );

  // Behavioural model: owner 0 idle, 1 cam, 2 ir, 3 estop; deadlines kept as absolute edge numbers.
  int tgtDuty[8] = '{0, 96, 96, 64, 128, 192, 0, 0};
  int tgtDirL[8] = '{-1, 0, 1, 1, 1, 1, -1, -1};
  int tgtDirR[8] = '{-1, 1, 0, 1, 1, 1, -1, -1};
  int mOwner = 0, mCmd = 0, mLatched = 0, mTrip = 0;
  int mDuty[2] = '{0, 0};
  int mDir[2] = '{1, 1};
  int edgeNum = 0, lastCam = 0, irExpire = 0;
  bit irArmed = 1'b0;

  function automatic int targetDir(input int side, input int cmd, input int cur);
    int d;
    d = (side == 0) ? tgtDirL[cmd] : tgtDirR[cmd];
    return (d < 0) ? cur : d;
  endfunction

  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = 0; mCmd = 0; mLatched = 0; mTrip = 0;
      mDuty[0] = 0; mDuty[1] = 0; mDir[0] = 1; mDir[1] = 1;
      edgeNum = 0; lastCam = 0; irArmed = 1'b0;
    end else begin
      int want;
      edgeNum++;
      if (estop || mOwner == 3) begin
        mDuty[0] = 0;
        mDuty[1] = 0;
      end else begin
`ifdef DRIVE_RAMP_EN
        if (edgeNum % RDIV == 0) begin
          for (int s = 0; s < 2; s++) begin
            int tdir, td;
            tdir = targetDir(s, mCmd, mDir[s]);
            td = tgtDuty[mCmd];
            if (tdir != mDir[s]) begin
              if (mDuty[s] > 0) mDuty[s] = (mDuty[s] > RSTEP) ? mDuty[s] - RSTEP : 0;
              else mDir[s] = tdir;
            end else if (mDuty[s] < td) mDuty[s] = (td - mDuty[s] > RSTEP) ? mDuty[s] + RSTEP : td;
            else mDuty[s] = (mDuty[s] - td > RSTEP) ? mDuty[s] - RSTEP : td;
          end
        end
`else
        for (int s = 0; s < 2; s++) begin
          mDir[s] = targetDir(s, mCmd, mDir[s]);
          mDuty[s] = tgtDuty[mCmd];
        end
`endif
      end
      want = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
      if (estop) begin
        mOwner = 3; mLatched = 1; mCmd = 0;
      end else if (mOwner == 3) begin
        if (want == 0) begin mOwner = 0; mLatched = 0; end
      end else if (want != mOwner) begin
        mOwner = want; mCmd = 0; lastCam = edgeNum; irArmed = 1'b0;
      end else if (mOwner == 1) begin
        if (cam_valid) begin mCmd = int'(cam_drive); lastCam = edgeNum; mTrip = 0; end
        else if (edgeNum - lastCam >= WDOG) begin mTrip = 1; mCmd = 0; end
      end else if (mOwner == 2) begin
        if (ir_valid) begin mCmd = int'(ir_drive); irExpire = edgeNum + HOLD; irArmed = 1'b1; end
        else if (irArmed && edgeNum == irExpire) begin mCmd = 0; irArmed = 1'b0; end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_50) begin
    checkOutput("grant", int'(grant), (mOwner == 1) ? 1 : (mOwner == 2) ? 2 : 0);
    checkOutput("active_cmd", int'(active_cmd), mCmd);
    checkOutput("duty_l", int'(duty_l), mDuty[0]);
    checkOutput("duty_r", int'(duty_r), mDuty[1]);
    checkOutput("dir_l", int'(dir_l), mDir[0]);
    checkOutput("dir_r", int'(dir_r), mDir[1]);
    checkOutput("estop_latched", int'(estop_latched), mLatched);
    checkOutput("wdog_trip", int'(wdog_trip), mTrip);
  end

  // Drives one cycle of inputs, lets one rising edge sample them, then settles just after the edge.
  task automatic applyStimulus(input logic [1:0] m, input logic cv, input logic [2:0] cd,
                               input logic iv, input logic [2:0] id, input logic es);
    mode = m; cam_valid = cv; cam_drive = cd; ir_valid = iv; ir_drive = id; estop = es;
    @(posedge clk_50);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(mode, 1'b0, 3'd0, 1'b0, 3'd0, estop);
  endtask

  initial begin
    int rate;
    repeat (3) @(posedge clk_50);
    #1;
    checkOutput("reset grant", int'(grant), 0);
    checkOutput("reset active_cmd", int'(active_cmd), 0);
    checkOutput("reset duty_l", int'(duty_l), 0);
    checkOutput("reset dir_l", int'(dir_l), 1);
    checkOutput("reset estop_latched", int'(estop_latched), 0);
    checkOutput("reset wdog_trip", int'(wdog_trip), 0);
    rst_n = 1'b1;

    applyStimulus(2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(2'b01, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
    checkOutput("cam grant", int'(grant), 1);
    checkOutput("cam active_cmd", int'(active_cmd), 5);
`ifndef DRIVE_RAMP_EN
    idleCycles(1);
    checkOutput("snap duty_l", int'(duty_l), 192);
`endif
    idleCycles(60);
    checkOutput("ramp duty_l", int'(duty_l), 192);
    checkOutput("ramp duty_r", int'(duty_r), 192);

    applyStimulus(2'b01, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
`ifdef DRIVE_RAMP_EN
    idleCycles(20);
    checkOutput("brake dir_l", int'(dir_l), 1);
`endif
    idleCycles(100);
    checkOutput("reversed dir_l", int'(dir_l), 0);
    checkOutput("reversed duty_l", int'(duty_l), 96);
    checkOutput("right dir_r", int'(dir_r), 1);
    checkOutput("right duty_r", int'(duty_r), 96);

    applyStimulus(2'b01, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0);
    idleCycles(199);
    checkOutput("wdog pre trip", int'(wdog_trip), 0);
    checkOutput("wdog pre cmd", int'(active_cmd), 4);
    idleCycles(1);
    checkOutput("wdog trip", int'(wdog_trip), 1);
    checkOutput("wdog cmd", int'(active_cmd), 0);
    applyStimulus(2'b01, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
    checkOutput("wdog cleared", int'(wdog_trip), 0);

    idleCycles(60);
    applyStimulus(2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    checkOutput("estop duty_l", int'(duty_l), 0);
    checkOutput("estop duty_r", int'(duty_r), 0);
    checkOutput("estop latched", int'(estop_latched), 1);
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    checkOutput("estop held", int'(estop_latched), 1);
    checkOutput("estop grant", int'(grant), 0);
    applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    checkOutput("estop released", int'(estop_latched), 0);

    applyStimulus(2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(2'b10, 1'b1, 3'd5, 1'b1, 3'd3, 1'b0);
    checkOutput("ir grant", int'(grant), 2);
    checkOutput("ir active_cmd", int'(active_cmd), 3);
    idleCycles(99);
    checkOutput("ir hold", int'(active_cmd), 3);
    idleCycles(1);
    checkOutput("ir expiry", int'(active_cmd), 0);

    applyStimulus(2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(2'b01, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
    idleCycles(20);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset duty_l", int'(duty_l), 0);
    checkOutput("async reset grant", int'(grant), 0);
    checkOutput("async reset dir_r", int'(dir_r), 1);
    applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    rate = 8;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [1:0] m;
      logic es;
      if (cyc % 400 == 0) rate = $urandom_range(2, 300);
      m = mode;
      if ($urandom_range(0, 60) == 0) m = 2'($urandom_range(0, 3));
      es = estop ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 400) == 0);
      applyStimulus(m, ($urandom_range(0, rate) == 0), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, rate) == 0), 3'($urandom_range(0, 7)), es);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
